// File: rtl/interrupt_vector_ctrl_pkg.sv
// Shared definitions for the 6502 interrupt vector controller.
//   int_type_e : interrupt source encoding (IRQ=00, BRK=01, NMI=10, RES=11)
//   state_e    : vector-fetch sequencer states
//   VEC_*_LO   : low byte of each vector; the high byte is always low|1
//   vec_pulls  : ADL bit 2..0 pull-down pattern for a given source and byte
package interrupt_vector_ctrl_pkg;

    typedef enum logic [1:0] {
        INT_IRQ = 2'b00,
        INT_BRK = 2'b01,
        INT_NMI = 2'b10,
        INT_RES = 2'b11
    } int_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_VEC_LO = 2'b10,
        ST_VEC_HI = 2'b11
    } state_e;

    localparam logic [7:0] VEC_NMI_LO = 8'hFA;
    localparam logic [7:0] VEC_RES_LO = 8'hFC;
    localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

    // ADL is precharged high, so a bit that must read 0 is pulled.
    // Only bits 2..0 differ between vectors; the high byte sets bit 0.
    function automatic logic [2:0] vec_pulls(input int_type_e t, input logic hi);
        logic [2:0] v;
        case (t)
            INT_NMI: v = VEC_NMI_LO[2:0];
            INT_RES: v = VEC_RES_LO[2:0];
            default: v = VEC_IRQ_LO[2:0];
        endcase
        v[0] = hi;
        return ~v;
    endfunction

endpackage

// File: rtl/interrupt_vector_ctrl_pin_sync.sv
// Multi-flop synchroniser for an active-low asynchronous pin.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset (chain resets to "pin high")
//   i_pin          : raw asynchronous pin
//   o_low          : synchronised pin level is low
//   o_fall         : one-cycle pulse on a synchronised high->low transition
//                    (only when EDGE_EN = 1, otherwise tied 0)
module pin_sync #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_low,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
        end
    end

    assign o_low = ~r_sync[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_prev <= 1'b1;
                end else begin
                    r_prev <= r_sync[STAGES-1];
                end
            end

            assign o_fall = r_prev & ~r_sync[STAGES-1];
        end else begin : g_no_edge
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/interrupt_vector_ctrl.sv
// Interrupt arbitration and vector-fetch sequencer for the 6502 core.
// Synchronises RES/NMI/IRQ pins, latches NMI edges and power-on/pin reset,
// arbitrates RES > NMI > IRQ (BRK as software source) and sequences the two
// vector-byte fetches by driving the ADL constant-generator pull-downs.
// Ports:
//   CLK, RST_N            : clock, async active-low reset
//   RES_N_IN/NMI_N_IN/IRQ_N_IN : raw interrupt pins
//   I_FLAG                : interrupt-disable bit
//   INT_ACK, BRK_EXEC     : decoder takes interrupt / executes BRK (pulses)
//   VEC_START             : pushes done, start vector fetch (pulse)
//   INT_PENDING           : hardware interrupt pending
//   B_FLAG_PUSH           : B bit value for the pushed P
//   RES_ACTIVE            : reset sequence in progress
//   ADL_PULL0/1/2         : ADL bit pull-downs (to sig_ZERO/ONE/TWO)
//   PCL_LOAD, PCH_LOAD    : PC byte load strobes
//   SET_I                 : set I flag
//   VEC_DONE              : sequence complete (pulse)
module interrupt_vector_ctrl
    import interrupt_vector_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic RES_N_IN,
    input  logic NMI_N_IN,
    input  logic IRQ_N_IN,
    input  logic I_FLAG,
    input  logic INT_ACK,
    input  logic BRK_EXEC,
    input  logic VEC_START,
    output logic INT_PENDING,
    output logic B_FLAG_PUSH,
    output logic RES_ACTIVE,
    output logic ADL_PULL0,
    output logic ADL_PULL1,
    output logic ADL_PULL2,
    output logic PCL_LOAD,
    output logic PCH_LOAD,
    output logic SET_I,
    output logic VEC_DONE
);

    logic w_res_low, w_res_fall;
    logic w_nmi_low, w_nmi_fall;
    logic w_irq_low, w_irq_fall;
    logic w_unused_sync;

    state_e    r_state, w_state_nxt;
    int_type_e r_type, w_type_nxt, w_hw_type;
    logic      r_nmi_latched, r_res_latched, r_vec_done;
    logic      w_pend_raw, w_nmi_clr, w_res_clr;
    logic [2:0] w_pulls;

    pin_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_res_sync (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_pin  (RES_N_IN),
        .o_low  (w_res_low),
        .o_fall (w_res_fall)
    );

    pin_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_nmi_sync (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_pin  (NMI_N_IN),
        .o_low  (w_nmi_low),
        .o_fall (w_nmi_fall)
    );

    pin_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_irq_sync (
        .i_clk  (CLK),
        .i_rst_n(RST_N),
        .i_pin  (IRQ_N_IN),
        .o_low  (w_irq_low),
        .o_fall (w_irq_fall)
    );

    // NMI is edge-only and RES/IRQ are level-only.
    assign w_unused_sync = w_res_fall | w_irq_fall | w_nmi_low;

    assign w_pend_raw  = r_res_latched | r_nmi_latched | (w_irq_low & ~I_FLAG);
    // res_latched is 1 during reset, so the pending flag is masked there.
    assign INT_PENDING = RST_N & w_pend_raw;

    always_comb begin
        if (r_res_latched) begin
            w_hw_type = INT_RES;
        end else if (r_nmi_latched) begin
            w_hw_type = INT_NMI;
        end else begin
            w_hw_type = INT_IRQ;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_type;
        case (r_state)
            ST_IDLE: begin
                if (INT_ACK && w_pend_raw) begin
                    w_type_nxt  = w_hw_type;
                    w_state_nxt = ST_ARMED;
                end else if (BRK_EXEC) begin
                    w_type_nxt  = INT_BRK;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (VEC_START) begin
                    // NMI hijack: pushes are already done, only the vector changes.
                    if ((r_type == INT_IRQ || r_type == INT_BRK) && r_nmi_latched) begin
                        w_type_nxt = INT_NMI;
                    end
                    w_state_nxt = ST_VEC_LO;
                end
            end
            ST_VEC_LO: w_state_nxt = ST_VEC_HI;
            ST_VEC_HI: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
        // A reset pin aborts any sequence in progress.
        if (w_res_low) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_nmi_clr = (r_state == ST_VEC_LO) && (r_type == INT_NMI);
    assign w_res_clr = (r_state == ST_VEC_LO) && (r_type == INT_RES);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= ST_IDLE;
            r_type        <= INT_IRQ;
            r_nmi_latched <= 1'b0;
            r_res_latched <= 1'b1;
            r_vec_done    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_type        <= w_type_nxt;
            // A new set in the clearing cycle wins.
            r_nmi_latched <= w_nmi_fall | (r_nmi_latched & ~w_nmi_clr);
            r_res_latched <= w_res_low | (r_res_latched & ~w_res_clr);
            r_vec_done    <= (r_state == ST_VEC_HI) & ~w_res_low;
        end
    end

    always_comb begin
        B_FLAG_PUSH = 1'b0;
        RES_ACTIVE  = 1'b0;
        PCL_LOAD    = 1'b0;
        PCH_LOAD    = 1'b0;
        SET_I       = 1'b0;
        w_pulls     = 3'b000;
        case (r_state)
            ST_ARMED: begin
                B_FLAG_PUSH = (r_type == INT_BRK);
                RES_ACTIVE  = (r_type == INT_RES);
            end
            ST_VEC_LO: begin
                PCL_LOAD   = 1'b1;
                SET_I      = 1'b1;
                RES_ACTIVE = (r_type == INT_RES);
                w_pulls    = vec_pulls(r_type, 1'b0);
            end
            ST_VEC_HI: begin
                PCH_LOAD   = 1'b1;
                RES_ACTIVE = (r_type == INT_RES);
                w_pulls    = vec_pulls(r_type, 1'b1);
            end
            default: ;
        endcase
    end

    assign ADL_PULL0 = w_pulls[0];
    assign ADL_PULL1 = w_pulls[1];
    assign ADL_PULL2 = w_pulls[2];
    assign VEC_DONE  = r_vec_done;

endmodule

// File: tb/tb_interrupt_vector_ctrl.sv
// Self-checking bench for interrupt_vector_ctrl: directed scenarios followed
// by randomized interrupt traffic checked against an event-level model.
module tb_interrupt_vector_ctrl;

    localparam logic [1:0] T_IRQ = 2'b00;
    localparam logic [1:0] T_BRK = 2'b01;
    localparam logic [1:0] T_NMI = 2'b10;
    localparam logic [1:0] T_RES = 2'b11;

    logic CLK, RST_N, RES_N_IN, NMI_N_IN, IRQ_N_IN, I_FLAG;
    logic INT_ACK, BRK_EXEC, VEC_START;
    logic INT_PENDING, B_FLAG_PUSH, RES_ACTIVE;
    logic ADL_PULL0, ADL_PULL1, ADL_PULL2;
    logic PCL_LOAD, PCH_LOAD, SET_I, VEC_DONE;

    int total = 0;
    int bad   = 0;

    // model state
    logic m_nmi;

    interrupt_vector_ctrl #(.SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .RES_N_IN   (RES_N_IN),
        .NMI_N_IN   (NMI_N_IN),
        .IRQ_N_IN   (IRQ_N_IN),
        .I_FLAG     (I_FLAG),
        .INT_ACK    (INT_ACK),
        .BRK_EXEC   (BRK_EXEC),
        .VEC_START  (VEC_START),
        .INT_PENDING(INT_PENDING),
        .B_FLAG_PUSH(B_FLAG_PUSH),
        .RES_ACTIVE (RES_ACTIVE),
        .ADL_PULL0  (ADL_PULL0),
        .ADL_PULL1  (ADL_PULL1),
        .ADL_PULL2  (ADL_PULL2),
        .PCL_LOAD   (PCL_LOAD),
        .PCH_LOAD   (PCH_LOAD),
        .SET_I      (SET_I),
        .VEC_DONE   (VEC_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] vec_addr(input logic [1:0] t);
        case (t)
            T_NMI:   return 16'hFFFA;
            T_RES:   return 16'hFFFC;
            default: return 16'hFFFE;
        endcase
    endfunction

    // Byte the ADL bus would carry: precharged high, pulled bits read 0.
    function automatic logic [7:0] adl_byte();
        return {5'b11111, ~ADL_PULL2, ~ADL_PULL1, ~ADL_PULL0};
    endfunction

    task automatic ack(input logic a, input logic b);
        INT_ACK  = a;
        BRK_EXEC = b;
        step();
        INT_ACK  = 1'b0;
        BRK_EXEC = 1'b0;
    endtask

    task automatic pulse_nmi();
        NMI_N_IN = 1'b0;
        repeat (3) step();
        NMI_N_IN = 1'b1;
        repeat (3) step();
    endtask

    // From ARMED: issue VEC_START and check the whole fetch against vector t.
    task automatic run_vector(input logic [1:0] t);
        logic [15:0] va;
        logic [7:0]  lo;
        va = vec_addr(t);
        lo = va[7:0];
        VEC_START = 1'b1;
        step();
        VEC_START = 1'b0;
        chk8("lo_adl", adl_byte(), lo);
        chk1("lo_pcl", PCL_LOAD, 1'b1);
        chk1("lo_seti", SET_I, 1'b1);
        chk1("lo_pch", PCH_LOAD, 1'b0);
        chk1("lo_resact", RES_ACTIVE, t == T_RES);
        chk1("lo_done", VEC_DONE, 1'b0);
        step();
        chk8("hi_adl", adl_byte(), lo + 8'd1);
        chk1("hi_pch", PCH_LOAD, 1'b1);
        chk1("hi_pcl", PCL_LOAD, 1'b0);
        chk1("hi_seti", SET_I, 1'b0);
        chk1("hi_resact", RES_ACTIVE, t == T_RES);
        step();
        chk1("done_pulse", VEC_DONE, 1'b1);
        chk1("done_pch", PCH_LOAD, 1'b0);
        chk1("done_resact", RES_ACTIVE, 1'b0);
        chk8("done_adl", adl_byte(), 8'hFF);
        step();
        chk1("done_single", VEC_DONE, 1'b0);
    endtask

    initial begin
        logic        irq_low, ifl, pend, a, b, have;
        logic [1:0]  typ;
        int          act;

        RST_N = 1'b0; RES_N_IN = 1'b1; NMI_N_IN = 1'b1; IRQ_N_IN = 1'b1;
        I_FLAG = 1'b1; INT_ACK = 1'b0; BRK_EXEC = 1'b0; VEC_START = 1'b0;
        m_nmi = 1'b0;

        // reset state
        repeat (3) step();
        chk1("rst_pending", INT_PENDING, 1'b0);
        chk1("rst_pcl", PCL_LOAD, 1'b0);
        chk1("rst_pch", PCH_LOAD, 1'b0);
        chk1("rst_done", VEC_DONE, 1'b0);
        chk1("rst_resact", RES_ACTIVE, 1'b0);
        chk1("rst_bflag", B_FLAG_PUSH, 1'b0);
        chk1("rst_seti", SET_I, 1'b0);
        chk8("rst_adl", adl_byte(), 8'hFF);

        // power-on RES sequence
        RST_N = 1'b1;
        step(); step();
        chk1("por_pending", INT_PENDING, 1'b1);
        ack(1'b1, 1'b0);
        chk1("por_resact", RES_ACTIVE, 1'b1);
        chk1("por_bflag", B_FLAG_PUSH, 1'b0);
        run_vector(T_RES);
        chk1("por_cleared", INT_PENDING, 1'b0);

        // IRQ masking, then IRQ sequence with IRQ released after acknowledge
        IRQ_N_IN = 1'b0;
        repeat (4) step();
        chk1("irq_masked", INT_PENDING, 1'b0);
        I_FLAG = 1'b0;
        #1;
        chk1("irq_unmasked", INT_PENDING, 1'b1);
        ack(1'b1, 1'b0);
        IRQ_N_IN = 1'b1;
        chk1("irq_bflag", B_FLAG_PUSH, 1'b0);
        run_vector(T_IRQ);
        chk1("irq_idle_pending", INT_PENDING, 1'b0);

        // BRK alone
        ack(1'b0, 1'b1);
        chk1("brk_bflag", B_FLAG_PUSH, 1'b1);
        run_vector(T_BRK);

        // INT_ACK and BRK_EXEC together with IRQ pending: hardware wins
        IRQ_N_IN = 1'b0;
        repeat (4) step();
        ack(1'b1, 1'b1);
        IRQ_N_IN = 1'b1;
        chk1("ackbrk_bflag", B_FLAG_PUSH, 1'b0);
        run_vector(T_IRQ);

        // NMI hijack of BRK
        ack(1'b0, 1'b1);
        NMI_N_IN = 1'b0;
        repeat (5) step();
        chk1("hij_pending", INT_PENDING, 1'b1);
        chk1("hij_bflag", B_FLAG_PUSH, 1'b1);
        run_vector(T_NMI);
        chk1("hij_cleared", INT_PENDING, 1'b0);
        NMI_N_IN = 1'b1;
        repeat (4) step();

        // two NMI edges merge into one sequence
        pulse_nmi();
        pulse_nmi();
        chk1("nmi2_pending", INT_PENDING, 1'b1);
        ack(1'b1, 1'b0);
        run_vector(T_NMI);
        chk1("nmi2_cleared", INT_PENDING, 1'b0);
        ack(1'b1, 1'b0);
        VEC_START = 1'b1;
        step();
        VEC_START = 1'b0;
        chk1("nmi2_no_second", PCL_LOAD, 1'b0);
        step();

        // new NMI edge coincident with the VEC_LO clear stays latched
        pulse_nmi();
        ack(1'b1, 1'b0);
        NMI_N_IN = 1'b0;
        step();
        run_vector(T_NMI);
        chk1("nmi_setwins", INT_PENDING, 1'b1);
        NMI_N_IN = 1'b1;
        repeat (3) step();
        ack(1'b1, 1'b0);
        run_vector(T_NMI);
        chk1("nmi_setwins_clr", INT_PENDING, 1'b0);

        // RES pin during VEC_HI of an IRQ aborts the sequence
        IRQ_N_IN = 1'b0;
        repeat (4) step();
        ack(1'b1, 1'b0);
        IRQ_N_IN = 1'b1;
        VEC_START = 1'b1;
        RES_N_IN  = 1'b0;
        step();
        VEC_START = 1'b0;
        chk1("abort_lo_pcl", PCL_LOAD, 1'b1);
        step();
        chk1("abort_hi_pch", PCH_LOAD, 1'b1);
        step();
        chk1("abort_pch", PCH_LOAD, 1'b0);
        chk1("abort_done", VEC_DONE, 1'b0);
        chk1("abort_pcl", PCL_LOAD, 1'b0);
        chk1("abort_pending", INT_PENDING, 1'b1);
        step();
        chk1("abort_done2", VEC_DONE, 1'b0);
        RES_N_IN = 1'b1;
        repeat (4) step();
        ack(1'b1, 1'b0);
        chk1("abort_resact", RES_ACTIVE, 1'b1);
        run_vector(T_RES);
        chk1("abort_res_clr", INT_PENDING, 1'b0);

        // randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            irq_low  = 1'($urandom_range(0, 1));
            ifl      = 1'($urandom_range(0, 1));
            IRQ_N_IN = ~irq_low;
            I_FLAG   = ifl;
            if ($urandom_range(0, 3) == 0) begin
                pulse_nmi();
                m_nmi = 1'b1;
            end else begin
                repeat (6) step();
            end
            pend = m_nmi | (irq_low & ~ifl);
            chk1("rnd_pending", INT_PENDING, pend);

            act  = int'($urandom_range(0, 2));
            a    = (act != 1);
            b    = (act != 0);
            have = 1'b1;
            if (a && pend) begin
                typ = m_nmi ? T_NMI : T_IRQ;
            end else if (b) begin
                typ = T_BRK;
            end else begin
                typ  = T_IRQ;
                have = 1'b0;
            end
            ack(a, b);

            if (!have) begin
                VEC_START = 1'b1;
                step();
                VEC_START = 1'b0;
                chk1("rnd_ignored", PCL_LOAD, 1'b0);
                step();
            end else begin
                chk1("rnd_bflag", B_FLAG_PUSH, typ == T_BRK);
                chk1("rnd_resact", RES_ACTIVE, 1'b0);
                IRQ_N_IN = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) begin
                    pulse_nmi();
                    m_nmi = 1'b1;
                end
                if ((typ == T_IRQ || typ == T_BRK) && m_nmi) begin
                    typ = T_NMI;
                end
                run_vector(typ);
                if (typ == T_NMI) begin
                    m_nmi = 1'b0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
